// File: rtl/rv32i_alu_arb.sv
// rtl/rv32i_alu_arb.sv - round-robin arbiter sharing one rv32i_alu among NREQ requesters
module rv32i_alu_arb #(
  parameter int NREQ = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [6*NREQ-1:0]    i_req_op,
  input  logic [32*NREQ-1:0]   i_req_rs1,
  input  logic [32*NREQ-1:0]   i_req_rs2,
  input  logic [32*NREQ-1:0]   i_req_imm,
  output logic [NREQ-1:0]      o_rsp_valid,
  input  logic [NREQ-1:0]      i_rsp_ready,
  output logic [32*NREQ-1:0]   o_rsp_data,
  output logic [NREQ-1:0]      o_rsp_err,
  output logic [32:0]          o_alu_inst,
  output logic [31:0]          o_alu_rs1,
  output logic [31:0]          o_alu_rs2,
  output logic [31:0]          o_alu_imm,
  input  logic                 i_alu_rslt_valid,
  input  logic [31:0]          i_alu_rslt
);

  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [5:0] MAX_OP = 6'd32;

  // Arbitration state: last winner and the owner of the op the ALU is computing
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_tag;
  logic            r_tag_valid;

  // Per-requester tracking and one-entry response buffers
  logic [NREQ-1:0] r_inflight;
  logic [NREQ-1:0] r_full;
  logic [NREQ-1:0] r_err;
  logic [31:0]     r_data [NREQ];

  // Combinational arbitration results
  logic [NREQ-1:0] w_elig;
  logic            w_grant;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_idx;
  logic [5:0]      w_op;

  // Eligibility only depends on registered state besides the live valid bit
  assign w_elig = i_req_valid & ~r_inflight & ~r_full;

  // Round-robin search starting one past the last winner
  always_comb begin
    w_grant = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_grant && w_elig[w_idx]) begin
        w_grant = 1'b1;
        w_win   = w_idx;
      end
    end
    // Nothing is accepted while reset is being applied
    if (i_rst) begin
      w_grant = 1'b0;
    end
  end

  // Grant vector: at most one bit, the winner
  always_comb begin
    o_req_ready = '0;
    if (w_grant) begin
      o_req_ready[w_win] = 1'b1;
    end
  end

  // Steer the winner's op and operands to the ALU; idle cycles drive zeros
  always_comb begin
    w_op       = '0;
    o_alu_inst = '0;
    o_alu_rs1  = '0;
    o_alu_rs2  = '0;
    o_alu_imm  = '0;
    if (w_grant) begin
      w_op      = i_req_op [int'(w_win)*6  +: 6];
      o_alu_rs1 = i_req_rs1[int'(w_win)*32 +: 32];
      o_alu_rs2 = i_req_rs2[int'(w_win)*32 +: 32];
      o_alu_imm = i_req_imm[int'(w_win)*32 +: 32];
      // Codes above 32 are accepted but never strobe the ALU, so they come back as errors
      if (w_op <= MAX_OP) begin
        o_alu_inst = 33'd1 << w_op;
      end
    end
  end

  // Pointer and owner tag follow the grant; the tag lives exactly one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= LAST_IDX;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
    end else begin
      r_tag_valid <= w_grant;
      if (w_grant) begin
        r_ptr <= w_win;
        r_tag <= w_win;
      end
    end
  end

  // In-flight flag: set on grant, cleared when the result lands in the buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant && (int'(w_win) == i)) begin
          r_inflight[i] <= 1'b1;
        end else if (r_tag_valid && (int'(r_tag) == i)) begin
          r_inflight[i] <= 1'b0;
        end
      end
    end
  end

  // Response buffers: capture the ALU result for the tagged owner, drain on handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= '0;
      r_err  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        // A full buffer is never granted, so capture and drain never collide on one entry
        if (r_tag_valid && (int'(r_tag) == i)) begin
          r_full[i] <= 1'b1;
          r_err[i]  <= ~i_alu_rslt_valid;
          r_data[i] <= i_alu_rslt_valid ? i_alu_rslt : 32'd0;
        end else if (r_full[i] && i_rsp_ready[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Present buffer contents; they stay put until consumed
  always_comb begin
    o_rsp_valid = r_full;
    o_rsp_err   = r_err;
    o_rsp_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_rsp_data[i*32 +: 32] = r_data[i];
    end
  end

endmodule

// File: tb/tb_rv32i_alu_arb.sv
// tb/tb_rv32i_alu_arb.sv - directed scoreboard bench for rv32i_alu_arb with a behavioral ALU
module tb_rv32i_alu_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  op  [2];
  logic [31:0] rs1 [2];
  logic [31:0] rs2 [2];
  logic [31:0] imm [2];
  logic [11:0] req_op;
  logic [63:0] req_rs1, req_rs2, req_imm;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [32:0] alu_inst;
  logic [31:0] alu_rs1, alu_rs2, alu_imm;
  logic        alu_v;
  logic [31:0] alu_r;

  int checks = 0;
  int errors = 0;

  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  logic [32:0] mon_e;

  assign req_op  = {op[1], op[0]};
  assign req_rs1 = {rs1[1], rs1[0]};
  assign req_rs2 = {rs2[1], rs2[0]};
  assign req_imm = {imm[1], imm[0]};

  rv32i_alu_arb #(.NREQ(2)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_op        (req_op),
    .i_req_rs1       (req_rs1),
    .i_req_rs2       (req_rs2),
    .i_req_imm       (req_imm),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_rsp_err       (rsp_err),
    .o_alu_inst      (alu_inst),
    .o_alu_rs1       (alu_rs1),
    .o_alu_rs2       (alu_rs2),
    .o_alu_imm       (alu_imm),
    .i_alu_rslt_valid(alu_v),
    .i_alu_rslt      (alu_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(int o, logic [31:0] a, logic [31:0] b, logic [31:0] im);
    case (o)
      0:  return a + im;
      1:  return {31'd0, $signed(a) < $signed(im)};
      2:  return {31'd0, a < im};
      3:  return a ^ im;
      4:  return a | im;
      5:  return a & im;
      6:  return a << im[4:0];
      7:  return a >> im[4:0];
      8:  return $signed(a) >>> im[4:0];
      9:  return a + b;
      10: return a - b;
      11: return a << b[4:0];
      12: return {31'd0, $signed(a) < $signed(b)};
      13: return {31'd0, a < b};
      14: return a ^ b;
      15: return a >> b[4:0];
      16: return $signed(a) >>> b[4:0];
      17: return a | b;
      18: return a & b;
      19: return {31'd0, a == b};
      20: return {31'd0, a != b};
      21: return {31'd0, $signed(a) < $signed(b)};
      22: return {31'd0, $signed(a) >= $signed(b)};
      23: return {31'd0, a < b};
      24: return {31'd0, a >= b};
      default: return a + im;
    endcase
  endfunction

  // Behavioral ALU: one registered result per strobe, reset tied to ~RST_N
  always @(posedge clk) begin
    if (rst) begin
      alu_v <= 1'b0;
      alu_r <= '0;
    end else begin
      alu_v <= |alu_inst;
      alu_r <= '0;
      for (int b = 0; b < 33; b++) begin
        if (alu_inst[b]) alu_r <= alu_f(b, alu_rs1, alu_rs2, alu_imm);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [31:0] d, input logic e);
    if (i == 0) q0.push_back({e, d});
    else        q1.push_back({e, d});
  endtask

  // Response monitor: every handshake pops the owner's scoreboard entry
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          chk("rsp_unexpected", 64'(rsp_valid[i]), 64'd0);
        end else begin
          mon_e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("rsp_data", 64'(rsp_data[i*32 +: 32]), 64'(mon_e[31:0]));
          chk("rsp_err", 64'(rsp_err[i]), 64'(mon_e[32]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until every currently valid requester has been granted once, dropping each after its grant
  task automatic wait_grants(output logic [1:0] first);
    logic [1:0] want;
    logic [1:0] got;
    want  = req_valid;
    got   = '0;
    first = '0;
    for (int n = 0; n < 8 && got != want; n++) begin
      @(negedge clk);
      if (n == 0) first = req_ready;
      got = got | req_ready;
      tick();
      req_valid = req_valid & ~got;
    end
    chk("grant_all", 64'(got), 64'(want));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] first;
    int ngrant;
    int last0;
    logic [1:0] upd;

    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      op[i] = '0; rs1[i] = '0; rs2[i] = '0; imm[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_alu_inst", 64'(alu_inst), 64'd0);

    // Single ADD on requester 0, two-cycle latency
    tick();
    op[0] = 6'd9; rs1[0] = 32'd5; rs2[0] = 32'd7; req_valid = 2'b01;
    push(0, 32'd12, 1'b0);
    @(negedge clk);
    chk("add_ready", 64'(req_ready), 64'd1);
    chk("add_inst", 64'(alu_inst), 64'd1 << 9);
    chk("add_rs1", 64'(alu_rs1), 64'd5);
    chk("add_rs2", 64'(alu_rs2), 64'd7);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("add_t1_valid", 64'(rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("add_t2_valid", 64'(rsp_valid), 64'd1);

    // Round-robin with both requesters saturating
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op[i] = 6'd9; rs1[i] = 32'(100 * i); rs2[i] = 32'd3; imm[i] = '0;
    end
    req_valid = 2'b11;
    ngrant = 0;
    last0 = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      upd = '0;
      chk("rr_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) begin
          chk("rr_order", 64'(i), 64'(ngrant % 2));
          if (i == 0 && last0 >= 0) chk("rr_gap0", 64'(cyc - last0), 64'd3);
          if (i == 0) last0 = cyc;
          push(i, rs1[i] + 32'd3, 1'b0);
          upd[i] = 1'b1;
          ngrant++;
        end
      end
      tick();
      for (int i = 0; i < 2; i++) if (upd[i]) rs1[i] = rs1[i] + 32'd1;
    end
    chk("rr_count", 64'(ngrant), 64'd8);
    req_valid = '0;
    repeat (4) tick();

    // Backpressure on requester 1 with SLTI
    op[1] = 6'd1; rs1[1] = 32'hFFFF_FFFF; rs2[1] = '0; imm[1] = 32'd1;
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    push(1, 32'd1, 1'b0);
    @(negedge clk);
    chk("bp_grant", 64'(req_ready), 64'd2);
    for (int c = 1; c <= 10; c++) begin
      tick();
      @(negedge clk);
      chk("bp_no_regrant", 64'(req_ready[1]), 64'd0);
      if (c >= 2) begin
        chk("bp_hold_valid", 64'(rsp_valid[1]), 64'd1);
        chk("bp_hold_data", 64'(rsp_data[63:32]), 64'd1);
      end
    end
    tick();
    rsp_ready = 2'b11;
    push(1, 32'd1, 1'b0);
    @(negedge clk);
    chk("bp_consume_cycle", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("bp_regrant", 64'(req_ready), 64'd2);
    tick();
    req_valid = '0;

    // Invalid op code
    tick();
    op[0] = 6'd40; rs1[0] = 32'd123; rs2[0] = 32'd456; imm[0] = 32'd9;
    req_valid = 2'b01;
    push(0, 32'd0, 1'b1);
    @(negedge clk);
    chk("inv_ready", 64'(req_ready), 64'd1);
    chk("inv_inst", 64'(alu_inst), 64'd0);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("inv_t2_valid", 64'(rsp_valid[0]), 64'd1);

    // Branch and address ops in parallel
    tick();
    op[0] = 6'd23; rs1[0] = 32'd1; rs2[0] = 32'd2; imm[0] = '0;
    op[1] = 6'd32; rs1[1] = 32'h0000_1000; rs2[1] = '0; imm[1] = 32'hFFFF_FFFC;
    req_valid = 2'b11;
    push(0, 32'd1, 1'b0);
    push(1, 32'h0000_0FFC, 1'b0);
    wait_grants(first);
    repeat (4) tick();

    // Reset while an op is in flight
    op[0] = 6'd9; rs1[0] = 32'd1; rs2[0] = 32'd1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("mid_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    op[0] = 6'd9; rs1[0] = 32'd10; rs2[0] = 32'd20;
    op[1] = 6'd9; rs1[1] = 32'd7;  rs2[1] = 32'd8;
    req_valid = 2'b11;
    push(0, 32'd30, 1'b0);
    push(1, 32'd15, 1'b0);
    wait_grants(first);
    chk("mid_first_winner", 64'(first), 64'd1);
    repeat (6) tick();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_alu_arb.md
# rv32i_alu_arb

Round-robin arbiter and sequencer that shares the single rv32i_alu instance among NREQ requesters, e.g. the execute stage and an address-generation/debug unit. It accepts encoded operation requests on valid/ready handshakes and drives the ALU one-hot instruction strobes and operands. It tracks the one in-flight operation per requester and returns each registered ALU result to its owner through a per-requester one-entry response buffer.

## Interface
- NREQ, 2, number of requesters (legal 2..4)
- CLK  in  1  clock, all logic on posedge
- RST  in  1  synchronous, active-high reset; ALU reset wired as RST_N = ~RST
- REQ_VALID  in  NREQ  request valid per requester
- REQ_READY  out  NREQ  grant; combinational, at most one bit high
- REQ_OP  in  6*NREQ  op code per requester; 0..32 = ALU INST_* port order (ADDI=0 … AND=18, BEQ=19 … BGEU=24, LB=25 … SW=32)
- REQ_RS1 / REQ_RS2 / REQ_IMM  in  32*NREQ each  operands per requester
- RSP_VALID  out  NREQ  response available
- RSP_READY  in  NREQ  response consumed
- RSP_DATA  out  32*NREQ  result
- RSP_ERR  out  NREQ  1 = op code not executed by ALU (codes 33..63)
- ALU_INST  out  33  one-hot strobes to ALU INST_* in op-code order
- ALU_RS1 / ALU_RS2 / ALU_IMM  out  32 each  operands to ALU
- ALU_RSLT_VALID  in  1  ALU RSLT_VALID
- ALU_RSLT  in  32  ALU RSLT

## Operation
- Per-requester state: inflight[i] (1 bit); buffer {full[i], data[i], err[i]}.
- Eligible(i) = REQ_VALID[i] & !inflight[i] & !full[i]. All terms except REQ_VALID are registered.
- Round-robin: ptr holds last granted index. Search order is ptr+1, ptr+2, … mod NREQ. The first eligible requester wins; REQ_READY[win]=1 in the same cycle.
- On grant:
  - ALU_RS1/RS2/IMM = winner's operands.
  - ALU_INST = one-hot decode of REQ_OP when OP ≤ 32, else all zero.
  - Set inflight[win]; record owner tag; ptr <= win.
- No grant: ALU_INST = 0 and operands = 0. ptr holds.
- Cycle after a grant (owner tag valid):
  - data[tag] <= ALU_RSLT_VALID ? ALU_RSLT : 0.
  - err[tag] <= !ALU_RSLT_VALID.
  - full[tag] <= 1; inflight[tag] <= 0.
- RSP_VALID[i] = full[i]; RSP_DATA/RSP_ERR = buffer contents. Stable while RSP_VALID & !RSP_READY.
- RSP_VALID[i] & RSP_READY[i] clears full[i] at the clock edge.
- Consequences of registered eligibility:
  - A requester can be granted again no earlier than the cycle after its response is consumed.
  - Maximum rate per requester is 1 op / 3 cycles.
  - Different requesters can be granted on consecutive cycles, so the ALU accepts 1 op/cycle overall.
- Branch ops return 0/1 in bit 0. Load/store ops return RS1+IMM.

## Timing
- Reset, next edge:
  - ptr = NREQ-1, so requester 0 has first priority.
  - inflight, full and owner-tag valid all cleared.
  - RSP_VALID = 0, RSP_DATA = 0, RSP_ERR = 0, REQ_READY = 0, ALU_INST = 0.
- Reset mid-operation: the in-flight op is discarded and its ALU result in the following cycle is ignored. No response is produced for it.
- Latency:
  - Grant at cycle T.
  - ALU registers its result at the end of T.
  - Buffer captures at the end of T+1.
  - RSP_VALID high at T+2.
  - REQ→RSP latency is 2 cycles.
- Simultaneous capture into buffer j and consume of buffer i≠j in one cycle: both take effect.
- Capture into a full buffer cannot occur, because a requester with a full buffer is never granted.
- Invalid op (33..63): it is granted, no ALU strobe is asserted, and the response is RSP_ERR=1, RSP_DATA=0 at T+2.
- REQ_VALID may drop without a grant; no state changes.

## Test plan
- Single op: RST 1 cycle, then req0 op ADD (9) with RS1=5, RS2=7 → REQ_READY[0] in cycle T; RSP_VALID[0] at T+2 with RSP_DATA=12, RSP_ERR=0.
- Round-robin, NREQ=2: both requesters valid every cycle with RSP_READY=1 → grant order 0,1,0,1…; req0 grants spaced exactly 3 cycles apart; no cycle with two REQ_READY bits high.
- Backpressure: req1 SLTI (1) with RS1=0xFFFFFFFF, IMM=1, RSP_READY[1]=0 for 10 cycles → RSP_DATA[1]=1 held stable; req1 not re-granted until 1 cycle after RSP_READY[1]=1.
- Invalid op: REQ_OP=40 → ALU_INST=0 in the grant cycle; response RSP_ERR=1, RSP_DATA=0 at T+2.
- Branch/address ops: BLTU (23) with RS1=1, RS2=2 → 1. SW (32) with RS1=0x1000, IMM=0xFFFFFFFC → 0x00000FFC.
- Reset mid-flight: assert RST in cycle T+1 after a grant → RSP_VALID stays 0 for that op; after release, req0 wins first.
